// File: rtl/ins_pipe_ctrl.sv
// Instruction pipeline registers (ID/EX/MEM/WB) with load-use hazard stall, branch flush and PC enable.
// Optional macro RAW_STALL_EN: also stall on any RAW dependency against EX or MEM (no forwarding datapath).
module ins_pipe_ctrl #(
    parameter int                 INS_W   = 32,
    parameter logic [INS_W-1:0]   NOP_INS = 32'h00000013,
    parameter int                 CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid_i,
    input  logic [INS_W-1:0] if_ins_i,
    output logic             if_ready_o,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic [INS_W-1:0] id_ins_o,
    output logic [INS_W-1:0] ex_ins_o,
    output logic [INS_W-1:0] mem_ins_o,
    output logic [INS_W-1:0] wb_ins_o,
    output logic             hazard_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [INS_W-1:0] id_q, ex_q, mem_q, wb_q;
    logic [INS_W-1:0] id_d, ex_d, mem_d, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == OP_LOAD) ||
               (op == 7'b1100111) || (op == OP_STORE)   || (op == OP_BRANCH);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    logic [6:0] id_op, ex_op;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_match, stall;

    assign id_op  = id_q[6:0];
    assign id_rs1 = id_q[19:15];
    assign id_rs2 = id_q[24:20];
    assign ex_op  = ex_q[6:0];
    assign ex_rd  = ex_q[11:7];

    // x0 is never a real producer, so rd==0 is excluded before any rs compare
    assign ex_match = (ex_rd != 5'd0) &&
                      ((uses_rs1(id_op) && (id_rs1 == ex_rd)) ||
                       (uses_rs2(id_op) && (id_rs2 == ex_rd)));

`ifdef RAW_STALL_EN
    logic [6:0] mem_op;
    logic [4:0] mem_rd;
    logic       mem_match, ex_writer, mem_writer;

    assign mem_op     = mem_q[6:0];
    assign mem_rd     = mem_q[11:7];
    assign ex_writer  = (ex_op != OP_STORE) && (ex_op != OP_BRANCH);
    assign mem_writer = (mem_op != OP_STORE) && (mem_op != OP_BRANCH);
    assign mem_match  = (mem_rd != 5'd0) &&
                        ((uses_rs1(id_op) && (id_rs1 == mem_rd)) ||
                         (uses_rs2(id_op) && (id_rs2 == mem_rd)));
    assign stall = (ex_match && ex_writer) || (mem_match && mem_writer);
`else
    assign stall = ex_match && (ex_op == OP_LOAD);
`endif

    always_comb begin
        id_d       = id_q;
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        cnt_d      = cnt_q;
        pc_en_o    = 1'b0;
        if_ready_o = 1'b0;
        hazard_o   = 1'b0;
        // a busy dcache freezes everything, including pending redirects and stalls
        if (!rst && !mem_busy_i) begin
            if (branch_taken_i) begin
                id_d    = NOP_INS;
                ex_d    = NOP_INS;
                mem_d   = ex_q;
                wb_d    = mem_q;
                pc_en_o = 1'b1;
            end else if (stall) begin
                ex_d     = NOP_INS;
                mem_d    = ex_q;
                wb_d     = mem_q;
                hazard_o = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                id_d       = if_valid_i ? if_ins_i : NOP_INS;
                ex_d       = id_q;
                mem_d      = ex_q;
                wb_d       = mem_q;
                pc_en_o    = 1'b1;
                if_ready_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q  <= NOP_INS;
            ex_q  <= NOP_INS;
            mem_q <= NOP_INS;
            wb_q  <= NOP_INS;
            cnt_q <= '0;
        end else begin
            id_q  <= id_d;
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign id_ins_o    = id_q;
    assign ex_ins_o    = ex_q;
    assign mem_ins_o   = mem_q;
    assign wb_ins_o    = wb_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_ins_pipe_ctrl.sv
// Directed-vector bench for ins_pipe_ctrl: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_ins_pipe_ctrl;

    localparam logic [31:0] N     = 32'h00000013;
    localparam logic [31:0] ADD   = 32'h003100B3; // add x1,x2,x3
    localparam logic [31:0] LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] USE   = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] BEQ   = 32'h00000063; // beq x0,x0,0
    localparam logic [31:0] LW9   = 32'h0002A483; // lw x9,0(x5)
    localparam logic [31:0] ADD10 = 32'h00928533; // add x10,x5,x9
    localparam logic [31:0] LW0   = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD0  = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] ADDI7 = 32'h00100393; // addi x7,x0,1
    localparam logic [31:0] ADD8  = 32'h00738433; // add x8,x7,x7
    localparam logic [31:0] JUNK  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, branch_taken, mem_busy, pc_en, hazard;
    logic [31:0] if_ins, id_ins, ex_ins, mem_ins, wb_ins;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [31:0] id, ex, mem, wb;
        logic        haz, pc, rdy;
        logic [15:0] cnt;
        int          row;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row   = 0;
    logic stim_done = 1'b0;

    always #5 clk = ~clk;

    ins_pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid_i    (if_valid),
        .if_ins_i      (if_ins),
        .if_ready_o    (if_ready),
        .branch_taken_i(branch_taken),
        .mem_busy_i    (mem_busy),
        .pc_en_o       (pc_en),
        .id_ins_o      (id_ins),
        .ex_ins_o      (ex_ins),
        .mem_ins_o     (mem_ins),
        .wb_ins_o      (wb_ins),
        .hazard_o      (hazard),
        .stall_cnt_o   (stall_cnt)
    );

    // one row = one cycle: inputs held through the cycle, expected outputs seen before the next edge
    task automatic cyc(input logic r, input logic v, input logic [31:0] ins,
                       input logic br, input logic busy,
                       input logic [31:0] e_id, input logic [31:0] e_ex,
                       input logic [31:0] e_mem, input logic [31:0] e_wb,
                       input logic e_haz, input logic e_pc, input logic e_rdy,
                       input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_valid = v; if_ins = ins; branch_taken = br; mem_busy = busy;
        row++;
        e.id = e_id; e.ex = e_ex; e.mem = e_mem; e.wb = e_wb;
        e.haz = e_haz; e.pc = e_pc; e.rdy = e_rdy; e.cnt = e_cnt; e.row = row;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL row %0d %s: got %08h expected %08h", r, name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_ins",    e.row, id_ins,            e.id);
                chk("ex_ins",    e.row, ex_ins,            e.ex);
                chk("mem_ins",   e.row, mem_ins,           e.mem);
                chk("wb_ins",    e.row, wb_ins,            e.wb);
                chk("hazard",    e.row, {31'd0, hazard},   {31'd0, e.haz});
                chk("pc_en",     e.row, {31'd0, pc_en},    {31'd0, e.pc});
                chk("if_ready",  e.row, {31'd0, if_ready}, {31'd0, e.rdy});
                chk("stall_cnt", e.row, {16'd0, stall_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin : watchdog
        repeat (2000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, rows=%0d expected completion", row);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; if_valid = 1'b0; if_ins = JUNK; branch_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        //   rst v ins    br busy  id     ex     mem    wb     haz pc rdy cnt
        cyc(1, 0, JUNK,  0, 0,    N,     N,     N,     N,     0, 0, 0, 0);
        cyc(1, 0, JUNK,  0, 0,    N,     N,     N,     N,     0, 0, 0, 0);
`ifndef RAW_STALL_EN
        // normal flow
        cyc(0, 1, ADD,   0, 0,    N,     N,     N,     N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    ADD,   N,     N,     N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    N,     ADD,   N,     N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    N,     N,     ADD,   N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    N,     N,     N,     ADD,   0, 1, 1, 0);
        // load-use: one stall, fetch holds ADD on if_ins
        cyc(0, 1, LW,    0, 0,    N,     N,     N,     N,     0, 1, 1, 0);
        cyc(0, 1, USE,   0, 0,    LW,    N,     N,     N,     0, 1, 1, 0);
        cyc(0, 1, ADD,   0, 0,    USE,   LW,    N,     N,     1, 0, 0, 0);
        cyc(0, 1, ADD,   0, 0,    USE,   N,     LW,    N,     0, 1, 1, 1);
        cyc(0, 0, JUNK,  0, 0,    ADD,   USE,   N,     LW,    0, 1, 1, 1);
        cyc(0, 0, JUNK,  0, 0,    N,     ADD,   USE,   N,     0, 1, 1, 1);
        cyc(0, 0, JUNK,  0, 0,    N,     N,     ADD,   USE,   0, 1, 1, 1);
        cyc(0, 0, JUNK,  0, 0,    N,     N,     N,     ADD,   0, 1, 1, 1);
        // branch flush with beq in EX; LW on if_ins is dropped
        cyc(0, 1, BEQ,   0, 0,    N,     N,     N,     N,     0, 1, 1, 1);
        cyc(0, 1, ADD,   0, 0,    BEQ,   N,     N,     N,     0, 1, 1, 1);
        cyc(0, 1, LW,    1, 0,    ADD,   BEQ,   N,     N,     0, 1, 0, 1);
        cyc(0, 1, LW,    0, 0,    N,     N,     BEQ,   N,     0, 1, 1, 1);
        cyc(0, 1, USE,   0, 0,    LW,    N,     N,     BEQ,   0, 1, 1, 1);
        // mem_busy over load-use pair, then with branch, release -> flush
        cyc(0, 1, ADD,   0, 1,    USE,   LW,    N,     N,     0, 0, 0, 1);
        cyc(0, 1, ADD,   1, 1,    USE,   LW,    N,     N,     0, 0, 0, 1);
        cyc(0, 1, ADD,   1, 0,    USE,   LW,    N,     N,     0, 1, 0, 1);
        // rebuild pair, busy, release without branch -> stall
        cyc(0, 1, LW,    0, 0,    N,     N,     LW,    N,     0, 1, 1, 1);
        cyc(0, 1, USE,   0, 0,    LW,    N,     N,     LW,    0, 1, 1, 1);
        cyc(0, 1, ADD,   0, 1,    USE,   LW,    N,     N,     0, 0, 0, 1);
        cyc(0, 1, ADD,   0, 0,    USE,   LW,    N,     N,     1, 0, 0, 1);
        cyc(0, 1, ADD,   0, 0,    USE,   N,     LW,    N,     0, 1, 1, 2);
        // back-to-back loads, each dependency stalls once
        cyc(0, 1, LW,    0, 0,    ADD,   USE,   N,     LW,    0, 1, 1, 2);
        cyc(0, 1, LW9,   0, 0,    LW,    ADD,   USE,   N,     0, 1, 1, 2);
        cyc(0, 1, ADD10, 0, 0,    LW9,   LW,    ADD,   USE,   1, 0, 0, 2);
        cyc(0, 1, ADD10, 0, 0,    LW9,   N,     LW,    ADD,   0, 1, 1, 3);
        cyc(0, 0, JUNK,  0, 0,    ADD10, LW9,   N,     LW,    1, 0, 0, 3);
        cyc(0, 0, JUNK,  0, 0,    ADD10, N,     LW9,   N,     0, 1, 1, 4);
        // load to x0 never stalls
        cyc(0, 1, LW0,   0, 0,    N,     ADD10, N,     LW9,   0, 1, 1, 4);
        cyc(0, 1, ADD0,  0, 0,    LW0,   N,     ADD10, N,     0, 1, 1, 4);
        cyc(0, 0, JUNK,  0, 0,    ADD0,  LW0,   N,     ADD10, 0, 1, 1, 4);
        // reset during a stall
        cyc(0, 1, LW,    0, 0,    N,     ADD0,  LW0,   N,     0, 1, 1, 4);
        cyc(0, 1, USE,   0, 0,    LW,    N,     ADD0,  LW0,   0, 1, 1, 4);
        cyc(1, 1, ADD,   0, 0,    USE,   LW,    N,     ADD0,  0, 0, 0, 4);
        cyc(0, 0, JUNK,  0, 0,    N,     N,     N,     N,     0, 1, 1, 0);
        // ALU RAW pair: forwarding assumed, no stall
        cyc(0, 1, ADDI7, 0, 0,    N,     N,     N,     N,     0, 1, 1, 0);
        cyc(0, 1, ADD8,  0, 0,    ADDI7, N,     N,     N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    ADD8,  ADDI7, N,     N,     0, 1, 1, 0);
        cyc(0, 0, JUNK,  0, 0,    N,     ADD8,  ADDI7, N,     0, 1, 1, 0);
`else
        // ALU RAW pair: stall until producer leaves MEM
        cyc(0, 1, ADDI7, 0, 0,    N,     N,     N,     N,     0, 1, 1, 0);
        cyc(0, 1, ADD8,  0, 0,    ADDI7, N,     N,     N,     0, 1, 1, 0);
        cyc(0, 1, ADD,   0, 0,    ADD8,  ADDI7, N,     N,     1, 0, 0, 0);
        cyc(0, 1, ADD,   0, 0,    ADD8,  N,     ADDI7, N,     1, 0, 0, 1);
        cyc(0, 1, ADD,   0, 0,    ADD8,  N,     N,     ADDI7, 0, 1, 1, 2);
        cyc(0, 0, JUNK,  0, 0,    ADD,   ADD8,  N,     N,     0, 1, 1, 2);
        cyc(0, 0, JUNK,  0, 0,    N,     ADD,   ADD8,  N,     0, 1, 1, 2);
`endif
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
